// File: rtl/snap_pkg.sv
// Shared types and constants for the snapshot bank.
package snap_pkg;
  typedef enum logic {MODE_LIVE = 1'b0, MODE_STORED = 1'b1} mode_e;
  localparam int unsigned SNAP_DEB_DEFAULT = 1000000;
endpackage

// File: rtl/snap_bank_btn.sv
// Button conditioner: 2-FF sync, debounce, rising-edge pulse.
// SNAP_DEBOUNCE_EN selects the debounce counter; otherwise the synced level is used directly.
module btn_cond
  import snap_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = SNAP_DEB_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  logic [1:0] sync;
  logic       lvl;
  logic       lvl_q;

  // Levels reset to "pressed" so a button held through reset must be
  // released and pressed again before it yields a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], btn};
  end

`ifdef SNAP_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl <= 1'b1;
      cnt <= '0;
    end else if (sync[1] == lvl) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      lvl <= sync[1];
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign lvl = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= 1'b1;
    else        lvl_q <= lvl;
  end

  assign pulse = lvl & ~lvl_q;
endmodule

// File: rtl/snap_bank.sv
// Snapshot bank: captures synced switch data into a DEPTH-slot ring and shows live or stored data.
// Debounce is enabled by defining SNAP_DEBOUNCE_EN.
module snap_bank
  import snap_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DEB_CYCLES = SNAP_DEB_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_cap,
  input  logic                     btn_view,
  input  logic                     btn_mode,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         led,
  output logic [$clog2(DEPTH)-1:0] view_idx,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     mode_led
);
  localparam int IW = $clog2(DEPTH);

  logic [1:0] rst_sync;
  logic       rst_int;

  // Async assert, sync release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int = rst_sync[1];

  logic [2:0] btn_raw, pls;
  assign btn_raw = {btn_mode, btn_view, btn_cap};

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk  (clk),
      .rst_n(rst_int),
      .btn  (btn_raw[gi]),
      .pulse(pls[gi])
    );
  end

  logic cap_p, view_p, mode_p;
  assign cap_p  = pls[0];
  assign view_p = pls[1];
  assign mode_p = pls[2];

  logic [1:0][WIDTH-1:0]     data_pipe;
  logic [WIDTH-1:0]          data_s;
  logic [DEPTH-1:0][WIDTH-1:0] slot;
  logic [IW-1:0]             wr_ptr, wr_nxt, view_nxt;
  logic [IW:0]               fill_nxt;
  mode_e                     mode, mode_nxt;
  logic [WIDTH-1:0]          rd, led_nxt;

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) data_pipe <= '0;
    else          data_pipe <= {data_pipe[0], data};
  end
  assign data_s = data_pipe[1];

  // Next state; led is computed from next-state values so it tracks
  // view_idx/mode on the same edge.
  always_comb begin
    wr_nxt   = wr_ptr;
    view_nxt = view_idx;
    fill_nxt = fill;
    mode_nxt = mode;
    if (mode_p) mode_nxt = (mode == MODE_LIVE) ? MODE_STORED : MODE_LIVE;
    if (cap_p) begin
      wr_nxt   = wr_ptr + 1'b1;
      fill_nxt = (fill == (IW+1)'(DEPTH)) ? fill : fill + 1'b1;
      view_nxt = wr_ptr;
    end else if (view_p && fill != '0) begin
      view_nxt = (({1'b0, view_idx} + 1'b1) == fill) ? '0 : view_idx + 1'b1;
    end
    rd      = cap_p ? data_s : slot[view_nxt];
    led_nxt = (mode_nxt == MODE_LIVE) ? data_s :
              (fill_nxt == '0)        ? '0     : rd;
  end

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      slot     <= '0;
      wr_ptr   <= '0;
      view_idx <= '0;
      fill     <= '0;
      mode     <= MODE_LIVE;
      led      <= '0;
    end else begin
      if (cap_p) slot[wr_ptr] <= data_s;
      wr_ptr   <= wr_nxt;
      view_idx <= view_nxt;
      fill     <= fill_nxt;
      mode     <= mode_nxt;
      led      <= led_nxt;
    end
  end

  assign mode_led = (mode == MODE_STORED);
endmodule

// File: tb/tb_snap_bank.sv
// Directed self-checking bench for snap_bank (WIDTH=8, DEPTH=4, DEB_CYCLES=4).
module tb_snap_bank;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_cap = 1'b0, btn_view = 1'b0, btn_mode = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] led;
  logic [1:0] view_idx;
  logic [2:0] fill;
  logic       mode_led;

  int checks = 0;
  int failures = 0;

  snap_bank #(.WIDTH(8), .DEPTH(4), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn_cap(btn_cap), .btn_view(btn_view),
    .btn_mode(btn_mode), .data(data), .led(led), .view_idx(view_idx),
    .fill(fill), .mode_led(mode_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(14);
  endtask

  // mask bit0=cap, bit1=view, bit2=mode
  task automatic press(input logic [2:0] mask, input int hold);
    @(negedge clk);
    {btn_mode, btn_view, btn_cap} = mask;
    wait_neg(hold);
    {btn_mode, btn_view, btn_cap} = 3'b000;
    wait_neg(14);
  endtask

  task automatic capture(input logic [7:0] d);
    data = d;
    wait_neg(3);
    press(3'b001, 12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic glitch_caps;
`ifdef SNAP_DEBOUNCE_EN
    glitch_caps = 1'b0;
`else
    glitch_caps = 1'b1;
`endif
    // 1: reset state and LIVE latency
    do_reset();
    chk("rst_led", led, 8'h00);
    chk("rst_fill", fill, 3'd0);
    chk("rst_mode", mode_led, 1'b0);
    chk("rst_view", view_idx, 2'd0);
    @(negedge clk);
    data = 8'hA5;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("live_lat2", led, 8'h00);
    @(posedge clk); @(negedge clk);
    chk("live_lat3", led, 8'hA5);

    // 2: five captures wrap the ring
    capture(8'h11); capture(8'h22); capture(8'h33); capture(8'h44); capture(8'h55);
    chk("ring_fill", fill, 3'd4);
    chk("ring_view", view_idx, 2'd0);
    data = 8'h00;
    press(3'b100, 12);
    chk("stored_mode", mode_led, 1'b1);
    chk("stored_led0", led, 8'h55);

    // 3: step through slots
    press(3'b010, 12);
    chk("view1_idx", view_idx, 2'd1); chk("view1_led", led, 8'h22);
    press(3'b010, 12);
    chk("view2_idx", view_idx, 2'd2); chk("view2_led", led, 8'h33);
    press(3'b010, 12);
    chk("view3_idx", view_idx, 2'd3); chk("view3_led", led, 8'h44);
    press(3'b010, 12);
    chk("view0_idx", view_idx, 2'd0); chk("view0_led", led, 8'h55);

    // 4: glitch then long hold
    data = 8'h66;
    wait_neg(3);
    press(3'b001, 2);
    chk("glitch_view", view_idx, glitch_caps ? 2'd1 : 2'd0);
    chk("glitch_led", led, glitch_caps ? 8'h66 : 8'h55);
    press(3'b001, 40);
    chk("hold_view", view_idx, glitch_caps ? 2'd2 : 2'd1);
    chk("hold_led", led, 8'h66);
    chk("hold_fill", fill, 3'd4);

    // 5: simultaneous cap/view/mode
    do_reset();
    capture(8'hAA); capture(8'hBB);
    chk("pre_sim_fill", fill, 3'd2);
    chk("pre_sim_view", view_idx, 2'd1);
    data = 8'hCC;
    wait_neg(3);
    press(3'b111, 12);
    chk("sim_fill", fill, 3'd3);
    chk("sim_view", view_idx, 2'd2);
    chk("sim_mode", mode_led, 1'b1);
    chk("sim_led", led, 8'hCC);

    // 6: STORED with empty ring, then async reset
    do_reset();
    data = 8'hFF;
    press(3'b100, 12);
    chk("empty_mode", mode_led, 1'b1);
    chk("empty_led", led, 8'h00);
    press(3'b010, 12);
    chk("empty_view", view_idx, 2'd0);
    chk("empty_view_led", led, 8'h00);
    capture(8'hFF);
    chk("one_fill", fill, 3'd1);
    chk("one_led", led, 8'hFF);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", led, 8'h00);
    chk("arst_fill", fill, 3'd0);
    chk("arst_mode", mode_led, 1'b0);
    chk("arst_view", view_idx, 2'd0);
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
